// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// Shared FSM state type and select-encoding helpers for the multi-source
// IJTAG data override mux.
package firebird7_in_gate1_tessent_data_mux_pkg;

  typedef enum logic [0:0] {
    STEADY = 1'b0,
    HOLD   = 1'b1
  } state_e;

  localparam int unsigned HOLD_CNT_W = 4;

  // Width of the IJTAG source index; a single source still needs one bit.
  function automatic int unsigned calc_sel_w(input int unsigned num_src);
    return (num_src > 32'd1) ? $clog2(num_src) : 32'd1;
  endfunction

  // The functional path is encoded as one past the last IJTAG source index.
  function automatic int unsigned func_sel(input int unsigned num_src);
    return num_src;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_hold_ctrl.sv
// Source-switch controller: resolves the effective target, runs the hold
// window FSM and tells the data register when and from which source to load.
module firebird7_in_gate1_tessent_data_mux_hold_ctrl
  import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ijtag_select,
  input  logic [calc_sel_w(NUM_SRC)-1:0] ijtag_src_sel,
  output logic [calc_sel_w(NUM_SRC):0]   cur_sel,
  output logic                           load_en,
  output logic                           switch_busy,
  output logic                           sel_error
);

  localparam int unsigned SEL_W = calc_sel_w(NUM_SRC);
  localparam logic [SEL_W:0] FUNC_SEL = (SEL_W + 1)'(func_sel(NUM_SRC));
  localparam logic [SEL_W:0] ZERO_SEL = {(SEL_W + 1){1'b0}};
  localparam logic [HOLD_CNT_W-1:0] HOLD_RELOAD =
    (HOLD_CYCLES > 32'd0) ? HOLD_CNT_W'(HOLD_CYCLES - 32'd1) : 4'd0;
  localparam bit ZERO_HOLD  = (HOLD_CYCLES == 32'd0);
  localparam bit SINGLE_SRC = (NUM_SRC == 32'd1);

  state_e                state_r, state_nxt_s;
  logic [SEL_W:0]        cur_sel_r, cur_sel_nxt_s;
  logic [SEL_W:0]        pend_sel_r, pend_sel_nxt_s;
  logic [HOLD_CNT_W-1:0] hold_cnt_r, hold_cnt_nxt_s;
  logic [SEL_W:0]        tgt_s;
  logic                  bad_sel_s;
  logic                  load_en_s;
  logic                  switch_busy_r;
  logic                  sel_error_r;

  // Effective target; an out-of-range index falls back to source 0.
  always_comb begin
    tgt_s     = FUNC_SEL;
    bad_sel_s = 1'b0;
    if (!ijtag_select) begin
      tgt_s = FUNC_SEL;
    end else if (SINGLE_SRC) begin
      tgt_s = ZERO_SEL;
    end else if ({1'b0, ijtag_src_sel} < FUNC_SEL) begin
      tgt_s = {1'b0, ijtag_src_sel};
    end else begin
      tgt_s     = ZERO_SEL;
      bad_sel_s = 1'b1;
    end
  end

  // Next-state logic for the hold window FSM.
  always_comb begin
    state_nxt_s    = state_r;
    cur_sel_nxt_s  = cur_sel_r;
    pend_sel_nxt_s = pend_sel_r;
    hold_cnt_nxt_s = hold_cnt_r;
    load_en_s      = 1'b0;
    case (state_r)
      STEADY: begin
        if (tgt_s == cur_sel_r) begin
          load_en_s = 1'b1;
        end else if (ZERO_HOLD) begin
          cur_sel_nxt_s = tgt_s;
          load_en_s     = 1'b1;
        end else begin
          state_nxt_s    = HOLD;
          pend_sel_nxt_s = tgt_s;
          hold_cnt_nxt_s = HOLD_RELOAD;
        end
      end
      HOLD: begin
        if (tgt_s != pend_sel_r) begin
          pend_sel_nxt_s = tgt_s;
          hold_cnt_nxt_s = HOLD_RELOAD;
        end else if (hold_cnt_r == 4'd0) begin
          state_nxt_s   = STEADY;
          cur_sel_nxt_s = pend_sel_r;
          load_en_s     = 1'b1;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = STEADY;
      end
    endcase
  end

  // FSM, select and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= STEADY;
      cur_sel_r     <= FUNC_SEL;
      pend_sel_r    <= FUNC_SEL;
      hold_cnt_r    <= 4'd0;
      switch_busy_r <= 1'b0;
      sel_error_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cur_sel_r     <= cur_sel_nxt_s;
      pend_sel_r    <= pend_sel_nxt_s;
      hold_cnt_r    <= hold_cnt_nxt_s;
      switch_busy_r <= (state_nxt_s == HOLD);
      sel_error_r   <= bad_sel_s;
    end
  end

  // cur_sel is the source committed on the coming edge; it only feeds registers.
  assign cur_sel     = cur_sel_nxt_s;
  assign load_en     = load_en_s;
  assign switch_busy = switch_busy_r;
  assign sel_error   = sel_error_r;

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_sync.sv
// Registered multi-source IJTAG data override mux with a programmable hold
// window on every change of the effective source.
module firebird7_in_gate1_tessent_data_mux_sync
  import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
  parameter int unsigned       WIDTH       = 19,
  parameter int unsigned       NUM_SRC     = 4,
  parameter int unsigned       HOLD_CYCLES = 2,
  parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                           ijtag_tck,
  input  logic                           ijtag_reset,
  input  logic                           ijtag_select,
  input  logic [calc_sel_w(NUM_SRC)-1:0] ijtag_src_sel,
  input  logic [NUM_SRC*WIDTH-1:0]       ijtag_data_in,
  input  logic [WIDTH-1:0]               functional_data_in,
  output logic [WIDTH-1:0]               data_out,
  output logic                           ijtag_active,
  output logic                           switch_busy,
  output logic                           sel_error
);

  localparam int unsigned SEL_W = calc_sel_w(NUM_SRC);
  localparam logic [SEL_W:0] FUNC_SEL = (SEL_W + 1)'(func_sel(NUM_SRC));

  logic [SEL_W:0]   cur_sel_s;
  logic             load_en_s;
  logic [WIDTH-1:0] src_bus_s [NUM_SRC];
  logic [WIDTH-1:0] mux_s;
  logic [WIDTH-1:0] data_out_r;
  logic             ijtag_active_r;

  firebird7_in_gate1_tessent_data_mux_hold_ctrl #(
    .NUM_SRC     (NUM_SRC),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_ctrl (
    .clk           (ijtag_tck),
    .rst_n         (ijtag_reset),
    .ijtag_select  (ijtag_select),
    .ijtag_src_sel (ijtag_src_sel),
    .cur_sel       (cur_sel_s),
    .load_en       (load_en_s),
    .switch_busy   (switch_busy),
    .sel_error     (sel_error)
  );

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign src_bus_s[k] = ijtag_data_in[k*WIDTH +: WIDTH];
  end

  // NUM_SRC+1 to 1 data mux; the sentinel select picks the functional bus.
  always_comb begin
    mux_s = functional_data_in;
    if (cur_sel_s < FUNC_SEL) begin
      mux_s = src_bus_s[cur_sel_s[SEL_W-1:0]];
    end else begin
      mux_s = functional_data_in;
    end
  end

  // Output register; holds its value while a switch is in its hold window.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      data_out_r     <= RESET_VALUE;
      ijtag_active_r <= 1'b0;
    end else begin
      ijtag_active_r <= (cur_sel_s != FUNC_SEL);
      if (load_en_s) begin
        data_out_r <= mux_s;
      end else begin
        data_out_r <= data_out_r;
      end
    end
  end

  assign data_out     = data_out_r;
  assign ijtag_active = ijtag_active_r;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_sync.sv
// Directed bench: three instances cover hold=2 with 4 sources, an invalid
// index with 3 sources, and zero-hold switching.
module tb_firebird7_in_gate1_tessent_data_mux_sync;

  localparam int W = 19;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         a_sel, b_sel, c_sel;
  logic [1:0]   a_src, b_src, c_src;
  logic [4*W-1:0] a_data, c_data;
  logic [3*W-1:0] b_data;
  logic [W-1:0] a_func, b_func, c_func;
  logic [W-1:0] a_out, b_out, c_out;
  logic         a_act, a_busy, a_err;
  logic         b_act, b_busy, b_err;
  logic         c_act, c_busy, c_err;
  logic [W-1:0] exp_v;

  int n_checks = 0;
  int n_pass   = 0;

  firebird7_in_gate1_tessent_data_mux_sync #(
    .WIDTH(W), .NUM_SRC(4), .HOLD_CYCLES(2), .RESET_VALUE(19'h2A5A5)
  ) u_dut_a (
    .ijtag_tck(clk), .ijtag_reset(rst_n), .ijtag_select(a_sel),
    .ijtag_src_sel(a_src), .ijtag_data_in(a_data), .functional_data_in(a_func),
    .data_out(a_out), .ijtag_active(a_act), .switch_busy(a_busy), .sel_error(a_err)
  );

  firebird7_in_gate1_tessent_data_mux_sync #(
    .WIDTH(W), .NUM_SRC(3), .HOLD_CYCLES(2), .RESET_VALUE(19'h00000)
  ) u_dut_b (
    .ijtag_tck(clk), .ijtag_reset(rst_n), .ijtag_select(b_sel),
    .ijtag_src_sel(b_src), .ijtag_data_in(b_data), .functional_data_in(b_func),
    .data_out(b_out), .ijtag_active(b_act), .switch_busy(b_busy), .sel_error(b_err)
  );

  firebird7_in_gate1_tessent_data_mux_sync #(
    .WIDTH(W), .NUM_SRC(4), .HOLD_CYCLES(0), .RESET_VALUE(19'h00000)
  ) u_dut_c (
    .ijtag_tck(clk), .ijtag_reset(rst_n), .ijtag_select(c_sel),
    .ijtag_src_sel(c_src), .ijtag_data_in(c_data), .functional_data_in(c_func),
    .data_out(c_out), .ijtag_active(c_act), .switch_busy(c_busy), .sel_error(c_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    a_sel  = 1'b0; a_src = 2'd0; a_func = 19'h12345;
    a_data = {19'h33333, 19'h7FFFF, 19'h22222, 19'h11111};
    b_sel  = 1'b0; b_src = 2'd0; b_func = 19'h0ABCD;
    b_data = {19'h2D2D2, 19'h1E1E1, 19'h0F0F0};
    c_sel  = 1'b0; c_src = 2'd1; c_func = 19'h04444;
    c_data = {19'h00000, 19'h00000, 19'h6AAAA, 19'h00000};

    // Reset values, then functional data one edge after release
    step(2);
    chk("rst_out", 32'(a_out), 32'h2A5A5);
    chk("rst_act", 32'(a_act), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_err", 32'(b_err), 32'd0);
    rst_n = 1'b1;
    step(1);
    chk("rel_out", 32'(a_out), 32'h12345);
    chk("rel_act", 32'(a_act), 32'd0);
    chk("rel_out_b", 32'(b_out), 32'h0ABCD);
    chk("rel_out_c", 32'(c_out), 32'h04444);

    // Switch to source 2 through a two-cycle hold window
    a_sel = 1'b1; a_src = 2'd2;
    step(1);
    chk("sw_busy1", 32'(a_busy), 32'd1);
    chk("sw_hold1", 32'(a_out), 32'h12345);
    chk("sw_act_hold", 32'(a_act), 32'd0);
    step(1);
    chk("sw_busy2", 32'(a_busy), 32'd1);
    chk("sw_hold2", 32'(a_out), 32'h12345);
    step(1);
    chk("sw_out", 32'(a_out), 32'h7FFFF);
    chk("sw_act", 32'(a_act), 32'd1);
    chk("sw_busy_done", 32'(a_busy), 32'd0);
    a_data[2*W +: W] = 19'h55555;
    step(1);
    chk("track_src2", 32'(a_out), 32'h55555);

    // Back to functional data
    a_sel = 1'b0;
    step(1);
    chk("tofunc_hold", 32'(a_out), 32'h55555);
    chk("tofunc_busy", 32'(a_busy), 32'd1);
    step(2);
    chk("tofunc_out", 32'(a_out), 32'h12345);
    chk("tofunc_act", 32'(a_act), 32'd0);

    // Restart mid-hold: 2 -> 3, source 2 value must never appear
    a_sel = 1'b1; a_src = 2'd2;
    step(1);
    chk("rs_busy", 32'(a_busy), 32'd1);
    a_src = 2'd3;
    step(1);
    chk("rs_hold1", 32'(a_out), 32'h12345);
    step(1);
    chk("rs_hold2", 32'(a_out), 32'h12345);
    chk("rs_busy2", 32'(a_busy), 32'd1);
    step(1);
    chk("rs_out", 32'(a_out), 32'h33333);
    chk("rs_act", 32'(a_act), 32'd1);
    chk("rs_busy_done", 32'(a_busy), 32'd0);

    // Target leaves and returns to cur_sel: full window, no value change
    a_src = 2'd0;
    step(1);
    chk("ret_busy1", 32'(a_busy), 32'd1);
    a_src = 2'd3;
    step(1);
    chk("ret_hold", 32'(a_out), 32'h33333);
    step(1);
    chk("ret_busy2", 32'(a_busy), 32'd1);
    step(1);
    chk("ret_busy_done", 32'(a_busy), 32'd0);
    chk("ret_out", 32'(a_out), 32'h33333);
    chk("ret_act", 32'(a_act), 32'd1);
    chk("a_err_quiet", 32'(a_err), 32'd0);

    // Invalid index on the 3-source instance
    b_sel = 1'b1; b_src = 2'd3;
    step(1);
    chk("inv_err1", 32'(b_err), 32'd1);
    chk("inv_busy", 32'(b_busy), 32'd1);
    chk("inv_hold", 32'(b_out), 32'h0ABCD);
    step(1);
    chk("inv_err2", 32'(b_err), 32'd1);
    step(1);
    chk("inv_out_src0", 32'(b_out), 32'h0F0F0);
    chk("inv_act", 32'(b_act), 32'd1);
    b_src = 2'd1;
    step(1);
    chk("inv_err_clear", 32'(b_err), 32'd0);
    chk("inv_busy2", 32'(b_busy), 32'd1);
    step(2);
    chk("inv_out_src1", 32'(b_out), 32'h1E1E1);

    // Zero hold: toggle select every cycle
    for (int i = 0; i < 6; i++) begin
      c_sel = (i % 2 == 0) ? 1'b1 : 1'b0;
      exp_v = c_sel ? 19'h6AAAA : 19'h04444;
      step(1);
      chk("zh_out", 32'(c_out), 32'(exp_v));
      chk("zh_busy", 32'(c_busy), 32'd0);
      chk("zh_act", 32'(c_act), 32'(c_sel));
    end

    // Asynchronous reset with hold_cnt == 1
    a_sel = 1'b0;
    step(1);
    chk("mr_busy", 32'(a_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_out", 32'(a_out), 32'h2A5A5);
    chk("mr_act", 32'(a_act), 32'd0);
    chk("mr_busy0", 32'(a_busy), 32'd0);
    chk("mr_err", 32'(a_err), 32'd0);
    step(2);
    chk("mr_out_held", 32'(a_out), 32'h2A5A5);
    rst_n = 1'b1;
    step(1);
    chk("mr_rel_out", 32'(a_out), 32'h12345);
    chk("mr_rel_act", 32'(a_act), 32'd0);
    chk("mr_rel_busy", 32'(a_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
